cpu_exec_ctrl: RTL and testbench

Execution sequencer between the board clock domain and the CPU core. It generates the CPU reset pulse and a cycle-enable. It implements run/pause/single-step from push-buttons, stops on CPU halt or a programmable cycle breakpoint, and counts enabled cycles. It runs on the divided CPU clock and replaces the free-running clear/clock arrangement at top level.

---
 rtl/cpu_exec_ctrl.sv | 76 +++++++
 tb/tb_cpu_exec_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl: CPU reset/cycle-enable sequencer with run, pause, single-step, halt and breakpoint control
module cpu_exec_ctrl #(
   parameter int RESET_CYCLES = 4,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             btn_run,
   input  logic             btn_step,
   input  logic             btn_reset,
   input  logic             halt,
   input  logic [CNT_W-1:0] cycle_count,
   input  logic             break_en,
   input  logic [CNT_W-1:0] break_cycle,
   output logic             cpu_clr,
   output logic             cpu_en,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] run_cycles
);
   localparam int RW = $clog2(RESET_CYCLES + 1);
   typedef enum logic [2:0] {
      RESET  = 3'd0,
      PAUSED = 3'd1,
      RUN    = 3'd2,
      STEP   = 3'd3,
      HALTED = 3'd4
   } state_t;
   state_t cur, nxt;
   logic [RW-1:0] rst_cnt;
   logic [2:0] s1, s2, s3;
   logic p_run, p_step, p_rst, brk_skip, brk_hit, rst_done;
   assign {p_rst, p_step, p_run} = s2 & ~s3;
   assign brk_hit  = break_en && (cycle_count == break_cycle) && !brk_skip && (cur == RUN);
   assign rst_done = rst_cnt == RW'(RESET_CYCLES - 1);
   assign cpu_en   = (cur == RUN && !halt && !brk_hit && !p_rst) || (cur == STEP && !halt);
   assign cpu_clr  = cur == RESET;
   assign state    = cur;
   // two-flop synchronisers plus a history flop turn each held button into one pulse
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= {btn_reset, btn_step, btn_run};
         s2 <= s1;
         s3 <= s2;
      end
   end
   // next state: reset beats halt beats breakpoint beats run beats step
   always_comb begin
      nxt = cur;
      case (cur)
         RESET:   nxt = p_rst ? RESET : rst_done ? PAUSED : RESET;
         PAUSED:  nxt = p_rst ? RESET : p_run ? RUN : p_step ? STEP : PAUSED;
         RUN:     nxt = p_rst ? RESET : halt ? HALTED : (brk_hit || p_run) ? PAUSED : RUN;
         STEP:    nxt = p_rst ? RESET : halt ? HALTED : PAUSED;
         HALTED:  nxt = p_rst ? RESET : HALTED;
         default: nxt = RESET;
      endcase
   end
   // state, reset timer, enabled-cycle counter and breakpoint re-trigger guard
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cur        <= RESET;
         rst_cnt    <= '0;
         run_cycles <= '0;
         brk_skip   <= 1'b0;
      end else begin
         cur        <= nxt;
         rst_cnt    <= (cur == RESET && nxt == RESET && !p_rst) ? rst_cnt + RW'(1) : '0;
         run_cycles <= (nxt == RESET) ? '0 : (cpu_en && !(&run_cycles)) ? run_cycles + CNT_W'(1) : run_cycles;
         brk_skip   <= (nxt == RESET) ? 1'b0 : (brk_hit && nxt == PAUSED) ? 1'b1 : cpu_en ? 1'b0 : brk_skip;
      end
   end
endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// tb_cpu_exec_ctrl: scoreboard bench for cpu_exec_ctrl; stimulus queues expected state changes and enabled cycles
module tb_cpu_exec_ctrl;
   localparam int RC = 4;
   logic clk = 1'b0;
   logic clr, btn_run, btn_step, btn_reset, halt, break_en, cpu_clr, cpu_en;
   logic [31:0] cycle_count, break_cycle, run_cycles;
   logic [2:0] state;
   typedef struct {int st; int rc;} ev_t;
   ev_t q_st[$];
   ev_t q_en[$];
   int n_pass = 0, n_total = 0, mc = 0, rst_len = 0, n_rst = 0, prev = 0;
   bit done = 0, fin = 0;

   cpu_exec_ctrl #(.RESET_CYCLES(RC), .CNT_W(32)) dut (
      .clk(clk), .clr(clr), .btn_run(btn_run), .btn_step(btn_step), .btn_reset(btn_reset),
      .halt(halt), .cycle_count(cycle_count), .break_en(break_en), .break_cycle(break_cycle),
      .cpu_clr(cpu_clr), .cpu_en(cpu_en), .state(state), .run_cycles(run_cycles)
   );

   always #5 clk = ~clk;
   assign cycle_count = run_cycles;

   task automatic check(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_state(input int s);
      if (s == 0) mc = 0;
      q_st.push_back('{s, mc});
   endtask

   task automatic exp_en(input int n, input int s);
      repeat (n) begin
         q_en.push_back('{s, mc});
         mc++;
      end
   endtask

   task automatic press(input bit r, input bit s, input bit rs, input int hold);
      btn_run = r;
      btn_step = s;
      btn_reset = rs;
      tick(hold);
      btn_run = 0;
      btn_step = 0;
      btn_reset = 0;
   endtask

   // monitor: pops an expectation for every state change and every enabled cycle
   always @(negedge clk) begin : mon
      ev_t e;
      if (cpu_clr) begin
         if (!clr) rst_len++;
      end else if (rst_len != 0) begin
         check("reset_len", rst_len, RC);
         n_rst++;
         rst_len = 0;
      end
      if (int'(state) != prev) begin
         prev = int'(state);
         if (q_st.size() == 0) begin
            n_total++;
            $display("FAIL state_change: got unexpected state %0d, required no change", state);
         end else begin
            e = q_st.pop_front();
            check("state", int'(state), e.st);
            check("run_cycles_at_state", int'(run_cycles), e.rc);
         end
      end
      if (cpu_en) begin
         if (q_en.size() == 0) begin
            n_total++;
            $display("FAIL cpu_en: got unexpected enable in state %0d run_cycles %0d, required none", state, run_cycles);
         end else begin
            e = q_en.pop_front();
            check("en_state", int'(state), e.st);
            check("en_run_cycles", int'(run_cycles), e.rc);
         end
      end
      if (done && !fin) begin
         check("state_queue_left", q_st.size(), 0);
         check("en_queue_left", q_en.size(), 0);
         check("reset_entries", n_rst, 5);
         fin = 1;
      end
   end

   initial begin
      clr = 1; btn_run = 0; btn_step = 0; btn_reset = 0; halt = 0; break_en = 0; break_cycle = 32'd20;
      exp_state(1);
      tick(3); clr = 0; tick(8);
      exp_state(2); exp_en(10, 2); exp_state(1);
      press(1, 0, 0, 3); tick(7); press(1, 0, 0, 3); tick(5);
      for (int i = 0; i < 3; i++) begin
         exp_state(3); exp_en(1, 3); exp_state(1);
         press(0, 1, 0, 10); tick(5);
      end
      break_en = 1;
      exp_state(2); exp_en(7, 2); exp_state(1);
      press(1, 0, 0, 3); tick(12);
      exp_state(2); exp_en(6, 2); exp_state(1);
      press(1, 0, 0, 3); tick(3); press(1, 0, 0, 3); tick(5);
      break_en = 0;
      exp_state(2); exp_en(3, 2); exp_state(4);
      press(1, 0, 0, 3); tick(3); halt = 1; tick(4);
      press(1, 0, 0, 3); tick(4); press(0, 1, 0, 3); tick(4);
      exp_state(0); exp_state(1);
      press(0, 0, 1, 3); tick(8);
      exp_state(2); exp_state(4);
      press(1, 0, 0, 3); tick(3);
      exp_state(0); exp_state(1);
      press(0, 0, 1, 3); tick(8);
      halt = 0;
      exp_state(2); exp_en(5, 2); exp_state(0); exp_state(1);
      press(1, 0, 0, 3); tick(3); press(1, 0, 1, 3); tick(8);
      exp_state(2); exp_en(2, 2); exp_state(0); exp_state(1);
      press(1, 0, 0, 3); tick(2); clr = 1; tick(2); clr = 0; tick(8);
      done = 1;
      tick(3);
      if (!fin) begin
         n_total++;
         $display("FAIL final_checks: got not run, required run");
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
